// File: rtl/ez8_instr_loader.sv
// Loads a framed instruction image into ez8_cpu instruction memory, holding the CPU while loading.
// Latency: write strobe one cycle after each INSTR_LO byte; reset request one cycle after the final byte.
// Backpressure: none; every rx_valid byte is consumed immediately.
//
// Ports:
//   clk, reset                 system clock, asynchronous active-high reset
//   rx_data, rx_valid          byte stream from the upstream byte source
//   instr_writeaddr/_writedata/_write_en   instruction memory write port
//   pause                      holds the CPU while a frame is loading or after a failed frame
//   cpu_reset_req              single-cycle pulse after a successful load
//   busy                       frame in progress
//   load_error                 last frame failed; cleared by the next SYNC_BYTE
//
// Build option: define EZ8_LOADER_CHECKSUM_EN to require and check a trailing checksum byte.
module ez8_instr_loader #(
   parameter int         ADDR_WIDTH     = 12,
   parameter logic [7:0] SYNC_BYTE      = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [ADDR_WIDTH-1:0] instr_writeaddr,
   output logic [15:0]           instr_writedata,
   output logic                  instr_write_en,
   output logic                  pause,
   output logic                  cpu_reset_req,
   output logic                  busy,
   output logic                  load_error
);

   localparam int                TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   // Largest image that fits the address space, in words.
   localparam logic [16:0]       MAX_WORDS = 17'(1) << ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
`ifdef EZ8_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_ERROR
   } state_t;

   state_t                state_q,    state_d;
   logic [7:0]            len_hi_q,   len_hi_d;
   logic [ADDR_WIDTH-1:0] last_idx_q, last_idx_d;
   logic [ADDR_WIDTH-1:0] idx_q,      idx_d;
   logic [7:0]            hi_q,       hi_d;
   logic [7:0]            sum_q,      sum_d;
   logic [TW-1:0]         tmo_q,      tmo_d;
   logic                  wr_en_q,    wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
   logic [15:0]           wr_data_q,  wr_data_d;
   logic                  rst_req_q,  rst_req_d;

   logic                  active;
   logic [15:0]           n_len;

   // Inside a frame means any state between SYNC and the end of the frame.
   assign active = (state_q != S_IDLE) && (state_q != S_ERROR);
   assign n_len  = {len_hi_q, rx_data};

   always_comb begin
      state_d    = state_q;
      len_hi_d   = len_hi_q;
      last_idx_d = last_idx_q;
      idx_d      = idx_q;
      hi_d       = hi_q;
      sum_d      = sum_q;
      tmo_d      = '0;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      rst_req_d  = 1'b0;

      // Inter-byte watchdog; a received byte always wins over an expiring count.
      if (active) begin
         if (rx_valid) begin
            tmo_d = '0;
         end else if (tmo_q == TMO_LAST) begin
            state_d = S_ERROR;
         end else begin
            tmo_d = tmo_q + TW'(1);
         end
      end

      case (state_q)
         S_IDLE, S_ERROR: begin
            if (rx_valid && (rx_data == SYNC_BYTE)) begin
               state_d = S_LEN_HI;
               sum_d   = '0;
               idx_d   = '0;
            end
         end
         S_LEN_HI: begin
            if (rx_valid) begin
               len_hi_d = rx_data;
               sum_d    = sum_q + rx_data;
               state_d  = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (rx_valid) begin
               sum_d = sum_q + rx_data;
               if ({1'b0, n_len} > MAX_WORDS) begin
                  state_d = S_ERROR;
               end else if (n_len == 16'd0) begin
`ifdef EZ8_LOADER_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  state_d   = S_IDLE;
                  rst_req_d = 1'b1;
`endif
               end else begin
                  state_d    = S_DATA_HI;
                  idx_d      = '0;
                  last_idx_d = ADDR_WIDTH'(n_len - 16'd1);
               end
            end
         end
         S_DATA_HI: begin
            if (rx_valid) begin
               hi_d    = rx_data;
               sum_d   = sum_q + rx_data;
               state_d = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            if (rx_valid) begin
               sum_d     = sum_q + rx_data;
               wr_en_d   = 1'b1;
               wr_addr_d = idx_q;
               wr_data_d = {hi_q, rx_data};
               idx_d     = idx_q + ADDR_WIDTH'(1);
               if (idx_q == last_idx_q) begin
`ifdef EZ8_LOADER_CHECKSUM_EN
                  state_d = S_CSUM;
`else
                  state_d   = S_IDLE;
                  rst_req_d = 1'b1;
`endif
               end else begin
                  state_d = S_DATA_HI;
               end
            end
         end
`ifdef EZ8_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (rx_valid) begin
               if (rx_data == sum_q) begin
                  state_d   = S_IDLE;
                  rst_req_d = 1'b1;
               end else begin
                  state_d = S_ERROR;
               end
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         len_hi_q   <= '0;
         last_idx_q <= '0;
         idx_q      <= '0;
         hi_q       <= '0;
         sum_q      <= '0;
         tmo_q      <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         rst_req_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         len_hi_q   <= len_hi_d;
         last_idx_q <= last_idx_d;
         idx_q      <= idx_d;
         hi_q       <= hi_d;
         sum_q      <= sum_d;
         tmo_q      <= tmo_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         rst_req_q  <= rst_req_d;
      end
   end

   assign instr_writeaddr = wr_addr_q;
   assign instr_writedata = wr_data_q;
   assign instr_write_en  = wr_en_q;
   assign cpu_reset_req   = rst_req_q;
   // pause falls in the same cycle the reset request pulses, since both follow the IDLE transition.
   assign pause           = (state_q != S_IDLE);
   assign busy            = active;
   assign load_error      = (state_q == S_ERROR);

endmodule
